// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op encodings, legality check and
// the arbiter FSM state type.
package alu_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] ALU_NOP = 3'd0;
  localparam logic [OPW-1:0] ALU_ADD = 3'd1;
  localparam logic [OPW-1:0] ALU_SUB = 3'd2;
  localparam logic [OPW-1:0] ALU_SHL = 3'd3;
  localparam logic [OPW-1:0] ALU_SHR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Takes the op zero-extended to 32 bits so callers with any op width can use it.
  function automatic logic op_legal(input logic [31:0] op);
    return (op >= 32'(ALU_ADD)) && (op <= 32'(ALU_SHR));
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the requester, response and ALU-side signals of the arbiter.
//   slave  : arbiter view (takes requests, drives responses and ALU inputs)
//   master : environment view (two requesters plus the ALU instance)
interface alu_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [OPW-1:0]   req_op0, req_op1;
  logic [WIDTH-1:0] req_a0, req_a1;
  logic [WIDTH-1:0] req_b0, req_b1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_err;
  logic [WIDTH-1:0] alu_in1, alu_in2;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             alu_z;

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
    input  rsp_ready, alu_out, alu_z,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err,
    output alu_in1, alu_in2, alu_op
  );

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
    output rsp_ready, alu_out, alu_z,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err,
    input  alu_in1, alu_in2, alu_op
  );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant.
//   req      : per-port request
//   acc      : a grant was accepted this cycle
//   acc_port : which port was accepted
//   gnt      : one-hot (or zero) grant; pointer picks the winner on a tie
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       acc,
  input  logic       acc_port,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;

  // Pointer moves to the port that was not just served.
  always_comb begin
    ptr_d = ptr_q;
    if (acc) ptr_d = ~acc_port;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters. Round-robin grant, drives
// the ALU for a single ISSUE cycle, waits out result and zero-flag latency,
// then presents result/zero/err to the requesting port until accepted.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requests (req_*), responses (rsp_*), ALU side (alu_*)
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int OPW     = 3,
  parameter int LAT_OUT = 1,
  parameter int LAT_Z   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  localparam int CNT_END = LAT_OUT + LAT_Z;
  localparam int CW      = $clog2(CNT_END + 1) < 1 ? 1 : $clog2(CNT_END + 1);

  typedef struct packed {
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             port_q, port_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       ready_q, ready_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [OPW-1:0]   op_q, op_d;

  logic [1:0] gnt;
  logic       accept, acc_port, acc_legal, rsp_hs;
  req_t [1:0] req;
  req_t       acc_req;

  assign req[0] = '{op: bus.req_op0, a: bus.req_a0, b: bus.req_b0};
  assign req[1] = '{op: bus.req_op1, a: bus.req_a1, b: bus.req_b1};

  // ready is only ever nonzero in IDLE, so an accept implies IDLE.
  assign accept    = |(bus.req_valid & ready_q);
  assign acc_port  = ready_q[1];
  assign acc_req   = req[acc_port];
  assign acc_legal = op_legal(32'(acc_req.op));
  assign rsp_hs    = (state_q == ST_RESP) && bus.rsp_ready[port_q];

  rr_arb2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus.req_valid),
    .acc      (accept),
    .acc_port (acc_port),
    .gnt      (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = acc_legal ? ST_ISSUE : ST_RESP;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (cnt_q == CW'(CNT_END)) state_d = ST_RESP;
      ST_RESP:  if (rsp_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    port_d      = port_q;
    res_d       = res_q;
    ready_d     = (state_d == ST_IDLE) ? gnt : 2'b00;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    op_d        = '0;  // nonzero for exactly one cycle so the ALU holds afterwards
    unique case (state_q)
      ST_IDLE: if (accept) begin
        port_d = acc_port;
        if (acc_legal) begin
          in1_d = acc_req.a;
          in2_d = acc_req.b;
          op_d  = acc_req.op;
        end else begin
          rsp_valid_d = {acc_port, ~acc_port};
          rsp_data_d  = '0;
          rsp_zero_d  = 1'b0;
          rsp_err_d   = 1'b1;
        end
      end
      ST_ISSUE: cnt_d = '0;
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LAT_OUT)) res_d = bus.alu_out;
        // z lags alu_out by LAT_Z edges; only sample it at the end of the count.
        if (cnt_q == CW'(CNT_END)) begin
          rsp_valid_d = {port_q, ~port_q};
          rsp_data_d  = (LAT_Z == 0) ? bus.alu_out : res_q;
          rsp_zero_d  = bus.alu_z;
          rsp_err_d   = 1'b0;
        end
      end
      ST_RESP: if (rsp_hs) rsp_valid_d = 2'b00;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      port_q      <= 1'b0;
      res_q       <= '0;
      ready_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      in1_q       <= '0;
      in2_q       <= '0;
      op_q        <= '0;
    end else begin
      cnt_q       <= cnt_d;
      port_q      <= port_d;
      res_q       <= res_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      op_q        <= op_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.alu_in1   = in1_q;
  assign bus.alu_in2   = in2_q;
  assign bus.alu_op    = op_q;
endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int mdl_ptr = 0;   // reference round-robin pointer

  alu_arbiter_if #(.WIDTH(16), .OPW(3)) bus();

  alu_arbiter #(.WIDTH(16), .OPW(3), .LAT_OUT(1), .LAT_Z(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ALU: registered result, holds when op==0; z registered one edge after result.
  logic [15:0] alu_r = 16'h0;
  logic        alu_zr = 1'b0;
  always @(posedge clk) begin
    case (bus.alu_op)
      3'd1: alu_r <= bus.alu_in1 + bus.alu_in2;
      3'd2: alu_r <= bus.alu_in2 - bus.alu_in1;
      3'd3: alu_r <= bus.alu_in1 << bus.alu_in2;
      3'd4: alu_r <= bus.alu_in1 >> bus.alu_in2;
      default: ;
    endcase
    alu_zr <= (alu_r == 16'h0);
  end
  assign bus.alu_out = alu_r;
  assign bus.alu_z   = alu_zr;

  // Reference: {err, zero, data} from plain arithmetic.
  function automatic logic [17:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned r;
    case (op)
      3'd1: r = (int'(a) + int'(b)) % 65536;
      3'd2: r = (int'(b) - int'(a) + 65536) % 65536;
      3'd3: r = (b > 16'd15) ? 0 : (int'(a) * (2 ** int'(b))) % 65536;
      3'd4: r = (b > 16'd15) ? 0 : int'(a) / (2 ** int'(b));
      default: return {1'b1, 1'b0, 16'h0};
    endcase
    return {1'b0, (r == 0), 16'(r)};
  endfunction

  function automatic logic [1:0] onehot(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic set_req(input int p, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (p == 0) begin bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b; end
    else        begin bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b; end
  endtask

  task automatic half_sample(output logic [1:0] acc, output logic [1:0] hs);
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    hs  = bus.rsp_valid & bus.rsp_ready;
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rnd_legal_op();
    return 3'($urandom_range(1, 4));
  endfunction

  function automatic logic [15:0] rnd_b(input logic [2:0] op);
    if (op == 3'd3 || op == 3'd4) return 16'($urandom_range(0, 17));
    return 16'($urandom);
  endfunction

  // Runs one op on port p with response ready high; returns what was observed.
  task automatic do_op(input int p, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [17:0] res, output logic [1:0] vld, output int lat, output int nop,
                       output logic [2:0] s_op, output logic [15:0] s_in1, output logic [15:0] s_in2,
                       output bit tmo);
    logic [1:0] acc, hs;
    bit got;
    tmo = 0; lat = 0; nop = 0; res = '0; vld = '0; s_op = '0; s_in1 = '0; s_in2 = '0; got = 0;
    set_req(p, op, a, b);
    bus.req_valid[p] = 1'b1;
    bus.rsp_ready[p] = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      half_sample(acc, hs);
      to_drive();
      if (acc[p]) got = 1;
    end
    bus.req_valid[p] = 1'b0;
    if (!got) tmo = 1;
    else begin
      mdl_ptr = 1 - p;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (bus.alu_op != 3'd0) begin
          nop++; s_op = bus.alu_op; s_in1 = bus.alu_in1; s_in2 = bus.alu_in2;
        end
        if (bus.rsp_valid != 2'b00) begin
          got = 1; vld = bus.rsp_valid;
          res = {bus.rsp_err, bus.rsp_zero, bus.rsp_data};
        end else lat++;
        to_drive();
      end
      if (!got) tmo = 1;
    end
  endtask

  function automatic logic [77:0] all_outs();
    return {bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_err,
            bus.alu_in1, bus.alu_in2, bus.alu_op};
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", all_outs()); end
    rst_n = 1'b1;
    to_drive();
  endtask

  task automatic test_add();
    logic [17:0] r; logic [1:0] v; int lat, nop; logic [2:0] so; logic [15:0] i1, i2; bit tmo;
    do_op(0, ALU_ADD, 16'd3, 16'd4, r, v, lat, nop, so, i1, i2, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL add_timeout got timeout want response"); end
    checks++; if (r !== {2'b00, 16'd7}) begin errors++; $display("FAIL add_result got %h want %h", r, {2'b00, 16'd7}); end
    checks++; if (v !== 2'b01) begin errors++; $display("FAIL add_port got %b want 01", v); end
    checks++; if (lat != 4) begin errors++; $display("FAIL add_latency got %0d want 4", lat); end
    checks++; if (nop != 1) begin errors++; $display("FAIL add_op_cycles got %0d want 1", nop); end
    checks++;
    if ({so, i1, i2} !== {3'd1, 16'd3, 16'd4}) begin
      errors++; $display("FAIL add_alu_drive got op %0d in1 %0d in2 %0d want 1 3 4", so, i1, i2);
    end
  endtask

  task automatic test_sub_zero();
    logic [17:0] r; logic [1:0] v; int lat, nop; logic [2:0] so; logic [15:0] i1, i2; bit tmo;
    do_op(1, ALU_SUB, 16'd5, 16'd5, r, v, lat, nop, so, i1, i2, tmo);
    checks++; if (tmo || r !== {2'b01, 16'h0} || v !== 2'b10) begin
      errors++; $display("FAIL sub_zero got %h port %b want %h port 10", r, v, {2'b01, 16'h0});
    end
    do_op(1, ALU_SUB, 16'd1, 16'd0, r, v, lat, nop, so, i1, i2, tmo);
    checks++; if (tmo || r !== {2'b00, 16'hFFFF} || v !== 2'b10) begin
      errors++; $display("FAIL sub_wrap got %h port %b want %h port 10", r, v, {2'b00, 16'hFFFF});
    end
  endtask

  task automatic test_illegal();
    logic [17:0] r; logic [1:0] v; int lat, nop; logic [2:0] so; logic [15:0] i1, i2; bit tmo;
    do_op(0, 3'd6, 16'h1234, 16'h5678, r, v, lat, nop, so, i1, i2, tmo);
    checks++; if (tmo || r !== {2'b10, 16'h0} || v !== 2'b01) begin
      errors++; $display("FAIL illegal_result got %h port %b want %h port 01", r, v, {2'b10, 16'h0});
    end
    checks++; if (nop != 0) begin errors++; $display("FAIL illegal_alu_activity got %0d want 0", nop); end
    checks++; if (lat != 0) begin errors++; $display("FAIL illegal_latency got %0d want 0", lat); end
  endtask

  task automatic test_random();
    logic [17:0] r, e; logic [1:0] v; int lat, nop, p; logic [2:0] so, op; logic [15:0] i1, i2, a, b; bit tmo;
    for (int k = 0; k < 16; k++) begin
      p  = int'($urandom_range(0, 1));
      op = (k % 4 == 3) ? 3'($urandom_range(5, 7)) : rnd_legal_op();
      a  = 16'($urandom);
      b  = rnd_b(op);
      if (k == 5) b = a;   // forces a zero SUB/ADD-wrap style corner now and then
      e  = model(op, a, b);
      do_op(p, op, a, b, r, v, lat, nop, so, i1, i2, tmo);
      checks++; if (tmo || r !== e) begin
        errors++; $display("FAIL rand_result[%0d] op %0d a %h b %h got %h want %h", k, op, a, b, r, e);
      end
      checks++; if (v !== onehot(p) || lat != (e[17] ? 0 : 4)) begin
        errors++; $display("FAIL rand_route[%0d] got port %b lat %0d want port %b lat %0d", k, v, lat, onehot(p), e[17] ? 0 : 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [2][6];
    logic [15:0] as_ [2][6];
    logic [15:0] bs [2][6];
    int idx [2];
    logic [1:0] acc, hs, eoh;
    logic [17:0] e;
    int nrsp, ep, gp, last_p, last_k;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 6; k++) begin
        ops[p][k] = rnd_legal_op(); as_[p][k] = 16'($urandom); bs[p][k] = rnd_b(ops[p][k]);
      end
    idx[0] = 0; idx[1] = 0; nrsp = 0; last_p = 0; last_k = 0;
    set_req(0, ops[0][0], as_[0][0], bs[0][0]);
    set_req(1, ops[1][0], as_[1][0], bs[1][0]);
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b11;
    for (int cyc = 0; cyc < 400 && nrsp < 12; cyc++) begin
      half_sample(acc, hs);
      if (acc != 2'b00) begin
        ep  = (bus.req_valid == 2'b11) ? mdl_ptr : (bus.req_valid[1] ? 1 : 0);
        eoh = onehot(ep);
        checks++; if (acc !== eoh) begin errors++; $display("FAIL b2b_grant got %b want %b", acc, eoh); end
        gp = acc[1] ? 1 : 0;
        mdl_ptr = 1 - gp; last_p = gp; last_k = idx[gp];
      end
      if (hs != 2'b00) begin
        e   = model(ops[last_p][last_k], as_[last_p][last_k], bs[last_p][last_k]);
        eoh = onehot(last_p);
        checks++; if (hs !== eoh) begin errors++; $display("FAIL b2b_route got %b want %b", hs, eoh); end
        checks++; if ({bus.rsp_err, bus.rsp_zero, bus.rsp_data} !== e) begin
          errors++; $display("FAIL b2b_result got %h want %h", {bus.rsp_err, bus.rsp_zero, bus.rsp_data}, e);
        end
        nrsp++;
      end
      to_drive();
      if (acc != 2'b00) begin
        gp = acc[1] ? 1 : 0;
        idx[gp]++;
        if (idx[gp] < 6) set_req(gp, ops[gp][idx[gp]], as_[gp][idx[gp]], bs[gp][idx[gp]]);
        else bus.req_valid[gp] = 1'b0;
      end
    end
    bus.req_valid = 2'b00;
    checks++; if (nrsp != 12) begin errors++; $display("FAIL b2b_count got %0d want 12", nrsp); end
  endtask

  task automatic test_backpressure();
    logic [17:0] e, e0, r, snap; logic [1:0] v, acc, hs; int lat, nop; logic [2:0] op, so;
    logic [15:0] a, b, a0, b0, i1, i2; bit got, stable, rdy, tmo;
    op = rnd_legal_op(); a = 16'($urandom); b = rnd_b(op); e = model(op, a, b);
    a0 = 16'($urandom); b0 = 16'($urandom); e0 = model(ALU_ADD, a0, b0);
    bus.rsp_ready = 2'b00;
    set_req(1, op, a, b);
    bus.req_valid[1] = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin half_sample(acc, hs); to_drive(); if (acc[1]) got = 1; end
    bus.req_valid[1] = 1'b0;
    mdl_ptr = 0;
    set_req(0, ALU_ADD, a0, b0);
    bus.req_valid[0] = 1'b1;   // competing request must not be granted during RESP
    got = 0; snap = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid[1]) begin got = 1; snap = {bus.rsp_err, bus.rsp_zero, bus.rsp_data}; end
      to_drive();
    end
    checks++; if (!got || snap !== e) begin errors++; $display("FAIL bp_result got %h want %h", snap, e); end
    stable = 1; rdy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_zero, bus.rsp_data} !== {2'b10, e}) stable = 0;
      if (bus.req_ready != 2'b00) rdy = 1;
      to_drive();
    end
    checks++; if (!stable) begin errors++; $display("FAIL bp_hold got unstable want stable"); end
    checks++; if (rdy) begin errors++; $display("FAIL bp_req_ready got 1 want 0"); end
    bus.rsp_ready[1] = 1'b1;
    half_sample(acc, hs);
    checks++; if (hs !== 2'b10) begin errors++; $display("FAIL bp_release got %b want 10", hs); end
    to_drive();
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL bp_drop got %b want 00", bus.rsp_valid); end
    to_drive();
    do_op(0, ALU_ADD, a0, b0, r, v, lat, nop, so, i1, i2, tmo);
    checks++; if (tmo || r !== e0 || v !== 2'b01) begin
      errors++; $display("FAIL bp_waiter got %h port %b want %h port 01", r, v, e0);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [17:0] r; logic [1:0] v, acc, hs; int lat, nop; logic [2:0] so; logic [15:0] i1, i2; bit got, tmo, stale;
    bus.rsp_ready = 2'b11;
    set_req(0, ALU_ADD, 16'h1234, 16'h1111);
    bus.req_valid[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin half_sample(acc, hs); to_drive(); if (acc[0]) got = 1; end
    bus.req_valid[0] = 1'b0;
    checks++; if (!got) begin errors++; $display("FAIL rst_accept got timeout want accept"); end
    to_drive();   // now in WAIT
    #2 rst_n = 1'b0;
    #1;
    checks++; if (all_outs() !== '0) begin errors++; $display("FAIL rst_async got %h want 0", all_outs()); end
    mdl_ptr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (bus.rsp_valid != 2'b00) stale = 1; end
    checks++; if (stale) begin errors++; $display("FAIL rst_stale_rsp got 1 want 0"); end
    to_drive();
    do_op(0, ALU_ADD, 16'd1, 16'd1, r, v, lat, nop, so, i1, i2, tmo);
    checks++; if (tmo || r !== {2'b00, 16'd2} || v !== 2'b01 || lat != 4) begin
      errors++; $display("FAIL rst_fresh_add got %h port %b lat %0d want %h port 01 lat 4", r, v, lat, {2'b00, 16'd2});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    set_req(0, 3'd0, 16'h0, 16'h0);
    set_req(1, 3'd0, 16'h0, 16'h0);
    test_reset();
    test_add();
    test_sub_zero();
    test_illegal();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
